// File: rtl/key_pulse_debouncer_if.sv
// Key/strobe bundle between the raw pushbuttons, key_pulse_debouncer and four_bit_counter.
// slave  : the debouncer (takes raw keys, drives strobes and debounced levels)
// master : the key source / observer side
interface key_pulse_debouncer_if;
  logic key_up_n;  // raw up button, active-low, asynchronous
  logic key_dn_n;  // raw down button, active-low, asynchronous
  logic count;     // one-cycle strobe per accepted up press
  logic deCount;   // one-cycle strobe per accepted down press
  logic up_held;   // debounced up level, 1 = pressed
  logic dn_held;   // debounced down level, 1 = pressed

  modport slave (
    input  key_up_n,
    input  key_dn_n,
    output count,
    output deCount,
    output up_held,
    output dn_held
  );

  modport master (
    output key_up_n,
    output key_dn_n,
    input  count,
    input  deCount,
    input  up_held,
    input  dn_held
  );
endinterface

// File: rtl/key_pulse_debouncer.sv
// key_pulse_debouncer: two raw active-low pushbuttons -> clean single-cycle count/deCount
// strobes plus debounced held levels. Per key: 2-flop synchronizer, debounce FSM,
// registered press-edge strobe. Simultaneous up/down strobes cancel each other.
// Optional feature macro: AUTO_REPEAT_EN (adds a per-key auto-repeat strobe generator
// and the REPEAT_DELAY / REPEAT_PERIOD parameters; REPEAT_PERIOD must not exceed
// REPEAT_DELAY). Default build (macro undefined): one strobe per accepted press.
module key_pulse_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
`endif
) (
  input logic                  clk,
  input logic                  reset,   // asynchronous, active-low
  key_pulse_debouncer_if.slave bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_PEND   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_PEND = 2'd3;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY);
  // After a repeat tick the counter restarts so that it reaches REP_FIRE again
  // exactly REPEAT_PERIOD cycles later.
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
`endif

  // Index 0 = up key, index 1 = down key.
  logic [1:0] w_raw_n;
  logic [1:0] w_held;
  logic [1:0] w_req;

  assign w_raw_n = {bus.key_dn_n, bus.key_up_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_held;
    logic          w_held_nxt;
    logic          r_held_d;
    logic          w_rise;

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
      end else begin
        r_sync1 <= w_raw_n[k];
        r_sync2 <= r_sync1;
      end
    end

    // Debounce FSM next-state: any disagreeing sample in a PEND state restarts acceptance.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_held_nxt  = r_held;
      case (r_state)
        S_RELEASED: begin
          if (!r_sync2) begin
            w_state_nxt = S_PRESS_PEND;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_cnt_nxt   = CNT_ZERO;
          end
        end
        S_PRESS_PEND: begin
          if (r_sync2) begin
            w_state_nxt = S_RELEASED;
            w_cnt_nxt   = CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_PRESSED;
            w_cnt_nxt   = CNT_ZERO;
            w_held_nxt  = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end
        S_PRESSED: begin
          if (r_sync2) begin
            w_state_nxt = S_RELEASE_PEND;
            w_cnt_nxt   = CNT_ONE;
          end else begin
            w_cnt_nxt   = CNT_ZERO;
          end
        end
        S_RELEASE_PEND: begin
          if (!r_sync2) begin
            w_state_nxt = S_PRESSED;
            w_cnt_nxt   = CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_RELEASED;
            w_cnt_nxt   = CNT_ZERO;
            w_held_nxt  = 1'b0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_RELEASED;
          w_cnt_nxt   = CNT_ZERO;
          w_held_nxt  = 1'b0;
        end
      endcase
    end

    // Debounce FSM state, counter, held level and its one-cycle-delayed copy.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state  <= S_RELEASED;
        r_cnt    <= CNT_ZERO;
        r_held   <= 1'b0;
        r_held_d <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_held   <= w_held_nxt;
        r_held_d <= r_held;
      end
    end

    assign w_rise    = r_held & ~r_held_d;
    assign w_held[k] = r_held;

`ifdef AUTO_REPEAT_EN
    logic [RW-1:0] r_rep_cnt;
    logic          w_tick;

    assign w_tick = r_held & (r_rep_cnt == REP_FIRE);

    // Repeat counter: runs while the debounced level is held, cleared once released.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_rep_cnt <= {RW{1'b0}};
      end else if (!r_held) begin
        r_rep_cnt <= {RW{1'b0}};
      end else if (w_tick) begin
        r_rep_cnt <= REP_RELOAD;
      end else begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end

    assign w_req[k] = w_rise | w_tick;
`else
    assign w_req[k] = w_rise;
`endif
  end

  assign bus.up_held = w_held[0];
  assign bus.dn_held = w_held[1];

  // Registered strobes; coincident up/down requests are both dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.count   <= 1'b0;
      bus.deCount <= 1'b0;
    end else begin
      bus.count   <= w_req[0] & ~w_req[1];
      bus.deCount <= w_req[1] & ~w_req[0];
    end
  end

endmodule

// File: tb/tb_key_pulse_debouncer.sv
// Directed bench for key_pulse_debouncer with DEBOUNCE_CYCLES=4 (REPEAT_DELAY=8,
// REPEAT_PERIOD=3 when AUTO_REPEAT_EN is defined). Edge n = n-th rising edge after
// the key is first driven; outputs are sampled on the following falling edge.
module tb_key_pulse_debouncer;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  key_pulse_debouncer_if bus();

  key_pulse_debouncer #(
    .DEBOUNCE_CYCLES(4)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then sample point on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, ".count"},   bus.count,   1'b0);
    check_value({tag, ".deCount"}, bus.deCount, 1'b0);
    check_value({tag, ".up_held"}, bus.up_held, 1'b0);
    check_value({tag, ".dn_held"}, bus.dn_held, 1'b0);
  endtask

  // Expected up strobe after press edge m when the key is released at edge rel:
  // initial strobe at 6, repeats at 14 + 3k while the held level persists.
  function automatic logic exp_up_strobe(input int m, input int rel);
    logic e;
    e = (m == 6);
    if (AR && m >= 14 && ((m - 14) % 3) == 0 && m <= rel + 5) e = 1'b1;
    return e;
  endfunction

  // Hold key_up_n low for len edges, then release and watch the held level fall.
  task automatic run_up_press(input string tag, input int len);
    bus.key_up_n = 1'b0;
    for (int n = 0; n < len + 10; n++) begin
      if (n == len) bus.key_up_n = 1'b1;
      step();
      check_value({tag, ".count"},   bus.count,   exp_up_strobe(n, len));
      check_value({tag, ".up_held"}, bus.up_held, (n >= 5) && (n < len + 5));
      check_value({tag, ".deCount"}, bus.deCount, 1'b0);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b0;
    bus.key_up_n = 1'b0;
    bus.key_dn_n = 1'b0;

    // 1: reset with both keys low, then idle high keys.
    repeat (3) @(negedge clk);
    check_all_zero("rst_keys_low");
    bus.key_up_n = 1'b1;
    bus.key_dn_n = 1'b1;
    reset        = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      check_all_zero("idle");
    end

    // 2: clean up press for 20 cycles, then release.
    run_up_press("up20", 20);

    // 3: bouncy press (low 3 / high 1, x4) followed by steady low.
    for (int n = 0; n < 30; n++) begin
      bus.key_up_n = (n < 16) ? ((n % 4) == 3) : 1'b0;
      step();
      check_value("bounce.count",   bus.count,   n == 22);
      check_value("bounce.up_held", bus.up_held, n >= 21);
    end
    bus.key_up_n = 1'b1;
    repeat (12) step();
    // Lone 3-cycle glitch.
    for (int n = 0; n < 12; n++) begin
      bus.key_up_n = (n < 3) ? 1'b0 : 1'b1;
      step();
      check_value("glitch.count",   bus.count,   1'b0);
      check_value("glitch.up_held", bus.up_held, 1'b0);
    end

    // 4a: both keys pressed on the same edge -> levels follow, strobes cancel.
    bus.key_up_n = 1'b0;
    bus.key_dn_n = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      check_value("both.up_held", bus.up_held, n >= 5);
      check_value("both.dn_held", bus.dn_held, n >= 5);
      check_value("both.count",   bus.count,   1'b0);
      check_value("both.deCount", bus.deCount, 1'b0);
    end
    bus.key_up_n = 1'b1;
    bus.key_dn_n = 1'b1;
    repeat (12) step();

    // 4b: down key lags up key by 2 cycles -> separate strobes.
    for (int n = 0; n < 12; n++) begin
      bus.key_up_n = 1'b0;
      if (n >= 2) bus.key_dn_n = 1'b0;
      step();
      check_value("stagger.count",   bus.count,   n == 6);
      check_value("stagger.deCount", bus.deCount, n == 8);
    end
    bus.key_up_n = 1'b1;
    bus.key_dn_n = 1'b1;
    repeat (14) step();

    // 5: reset mid-debounce of a down press, then resume with the key still low.
    bus.key_dn_n = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      check_value("pre_rst.deCount", bus.deCount, 1'b0);
    end
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      check_value("post_rst.deCount", bus.deCount, n == 6);
      check_value("post_rst.dn_held", bus.dn_held, n >= 5);
    end
    // Reset while held clears the level immediately.
    #2 reset = 1'b0;
    #1 check_all_zero("held_rst");
    bus.key_dn_n = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) step();

    // 6: long press -> repeat strobes only when auto-repeat is built in.
    run_up_press("up30", 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
